// File: rtl/tpu_pkg.sv
// Shared TPU constants and the unified-buffer scheduler state encoding.
package tpu_pkg;
  localparam int UB_DEPTH  = 64;
  localparam int UB_ADDR_W = 13;
  localparam int UB_BURST  = 4;

  typedef enum logic [1:0] {IDLE, WRITE, READ, DRAIN} ub_sched_state_t;
endpackage

// File: rtl/ub_ptr.sv
// Modulo-DEPTH buffer pointer: load, advance by BURST, sticky wrap flag.
module ub_ptr #(
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 13,
  parameter int BURST  = 4,
  parameter int BASE   = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_ld,
  input  logic [ADDR_W-1:0] i_val,
  input  logic              i_inc,
  output logic [ADDR_W-1:0] o_ptr,
  output logic              o_wrap
);
  localparam int PW = $clog2(DEPTH);

  logic [PW-1:0] r_ptr;
  logic          r_wrap;
  logic [PW:0]   w_sum;

  // Carry out of the low PW bits marks a crossing of the buffer end.
  assign w_sum = {1'b0, r_ptr} + (PW+1)'(BURST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ptr  <= PW'(BASE);
      r_wrap <= 1'b0;
    end else if (i_ld) begin
      r_ptr  <= i_val[PW-1:0];
      r_wrap <= 1'b0;
    end else if (i_inc) begin
      r_ptr <= w_sum[PW-1:0];
      if (w_sum[PW]) r_wrap <= 1'b1;
    end
  end

  assign o_ptr  = ADDR_W'(r_ptr);
  assign o_wrap = r_wrap;
endmodule

// File: rtl/ub_scheduler.sv
// Unified-buffer address-port arbiter/sequencer (Moore FSM, pointer wrap).
// Define UB_SCHED_RR_EN for round-robin arbitration; default is write priority.
module ub_scheduler
  import tpu_pkg::*;
#(
  parameter int UB_DEPTH = tpu_pkg::UB_DEPTH,
  parameter int ADDR_W   = tpu_pkg::UB_ADDR_W,
  parameter int BURST    = tpu_pkg::UB_BURST,
  parameter int WR_BASE  = 0,
  parameter int RD_BASE  = 30
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              acc1_full,
  input  logic              acc2_full,
  input  logic              rd_req,
  input  logic              ptr_ld,
  input  logic              ptr_sel,
  input  logic [ADDR_W-1:0] ptr_val,
  output logic              wr_ack,
  output logic              rd_ack,
  output logic              rd_valid,
  output logic [ADDR_W-1:0] ub_addr,
  output logic              ub_store,
  output logic              ub_load_input,
  output logic              busy,
  output logic [ADDR_W-1:0] wr_ptr,
  output logic [ADDR_W-1:0] rd_ptr,
  output logic              wr_wrap
);
  ub_sched_state_t   r_state, w_next;
  logic              w_wr_req;
  logic              w_wr_first;
  logic [ADDR_W-1:0] w_wr_ptr, w_rd_ptr;
  logic [ADDR_W-1:0] r_last_rd;

  assign w_wr_req = acc1_full & acc2_full;

`ifdef UB_SCHED_RR_EN
  // Token set means the read side is preferred on the next collision.
  logic r_tok_rd;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                                r_tok_rd <= 1'b0;
    else if (r_state == IDLE && w_next == WRITE) r_tok_rd <= 1'b1;
    else if (r_state == IDLE && w_next == READ)  r_tok_rd <= 1'b0;
  end

  assign w_wr_first = ~r_tok_rd;
`else
  assign w_wr_first = 1'b1;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_wr_req && (!rd_req || w_wr_first)) w_next = WRITE;
        else if (rd_req)                         w_next = READ;
      end
      WRITE:   w_next = IDLE;
      READ:    w_next = DRAIN;
      DRAIN:   w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // DRAIN presents the address of the tile that was just fetched.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)              r_last_rd <= '0;
    else if (r_state == READ) r_last_rd <= w_rd_ptr;
  end

  always_comb begin
    wr_ack        = 1'b0;
    rd_ack        = 1'b0;
    rd_valid      = 1'b0;
    ub_store      = 1'b0;
    ub_load_input = 1'b0;
    ub_addr       = '0;
    case (r_state)
      WRITE: begin
        ub_store = 1'b1;
        wr_ack   = 1'b1;
        ub_addr  = w_wr_ptr;
      end
      READ: begin
        ub_load_input = 1'b1;
        rd_ack        = 1'b1;
        ub_addr       = w_rd_ptr;
      end
      DRAIN: begin
        rd_valid = 1'b1;
        ub_addr  = r_last_rd;
      end
      default: ;
    endcase
  end

  assign busy = (r_state != IDLE);

  ub_ptr #(.DEPTH(UB_DEPTH), .ADDR_W(ADDR_W), .BURST(BURST), .BASE(WR_BASE)) u_wr_ptr (
    .clk    (clk),
    .reset  (reset),
    .i_ld   (ptr_ld & ~ptr_sel),
    .i_val  (ptr_val),
    .i_inc  (r_state == WRITE),
    .o_ptr  (w_wr_ptr),
    .o_wrap (wr_wrap)
  );

  ub_ptr #(.DEPTH(UB_DEPTH), .ADDR_W(ADDR_W), .BURST(BURST), .BASE(RD_BASE)) u_rd_ptr (
    .clk    (clk),
    .reset  (reset),
    .i_ld   (ptr_ld & ptr_sel),
    .i_val  (ptr_val),
    .i_inc  (r_state == READ),
    .o_ptr  (w_rd_ptr),
    .o_wrap ()
  );

  assign wr_ptr = w_wr_ptr;
  assign rd_ptr = w_rd_ptr;
endmodule

// File: tb/tb_ub_scheduler.sv
// Scoreboard bench for ub_scheduler: stimulus queues expected grants, a monitor checks them.
module tb_ub_scheduler;
  localparam int ADDR_W = 13;
  localparam int K_W = 0, K_R = 1, K_V = 2;

  logic              clk = 1'b0;
  logic              reset;
  logic              acc1_full, acc2_full, rd_req, ptr_ld, ptr_sel;
  logic [ADDR_W-1:0] ptr_val;
  logic              wr_ack, rd_ack, rd_valid, ub_store, ub_load_input, busy, wr_wrap;
  logic [ADDR_W-1:0] ub_addr, wr_ptr, rd_ptr;

  ub_scheduler dut (
    .clk(clk), .reset(reset), .acc1_full(acc1_full), .acc2_full(acc2_full),
    .rd_req(rd_req), .ptr_ld(ptr_ld), .ptr_sel(ptr_sel), .ptr_val(ptr_val),
    .wr_ack(wr_ack), .rd_ack(rd_ack), .rd_valid(rd_valid), .ub_addr(ub_addr),
    .ub_store(ub_store), .ub_load_input(ub_load_input), .busy(busy),
    .wr_ptr(wr_ptr), .rd_ptr(rd_ptr), .wr_wrap(wr_wrap)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    int kind;
    int addr;
    int at;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic expect_ev(input int kind, input int addr, input int at);
    exp_t e;
    e.kind = kind;
    e.addr = addr;
    e.at   = at;
    exp_q.push_back(e);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s got %0d want %0d", name, got, want);
    end
  endtask

  // Monitor: every grant/valid the DUT presents must match the next queued event.
  always @(negedge clk) begin
    int   gk;
    logic gs;
    exp_t e;
    if (wr_ack || rd_ack || rd_valid) begin
      gk = wr_ack ? K_W : (rd_ack ? K_R : K_V);
      gs = wr_ack ? ub_store : (rd_ack ? ub_load_input : !(ub_store || ub_load_input));
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_event kind=%0d addr=%0d cyc=%0d, none expected", gk, ub_addr, cyc);
      end else begin
        e = exp_q.pop_front();
        if (gk != e.kind || int'(ub_addr) != e.addr || cyc != e.at || !gs) begin
          errors++;
          $display("FAIL grant got kind=%0d addr=%0d cyc=%0d strobe_ok=%0d want kind=%0d addr=%0d cyc=%0d",
                   gk, ub_addr, cyc, gs, e.kind, e.addr, e.at);
        end
      end
    end
  end

  initial begin
    int c;
    reset = 1'b0;
    acc1_full = 1'b0; acc2_full = 1'b0; rd_req = 1'b0;
    ptr_ld = 1'b0; ptr_sel = 1'b0; ptr_val = '0;

    tick(2);
    chk("rst_wr_ptr", int'(wr_ptr), 0);
    chk("rst_rd_ptr", int'(rd_ptr), 30);
    chk("rst_flags", int'({ub_store, ub_load_input, wr_ack, rd_ack, rd_valid, busy, wr_wrap}), 0);
    chk("rst_addr", int'(ub_addr), 0);
    reset = 1'b1;
    tick(1);
    chk("rel_wr_ptr", int'(wr_ptr), 0);
    chk("rel_rd_ptr", int'(rd_ptr), 30);
    chk("rel_busy", int'(busy), 0);

    // single write pulse
    acc1_full = 1'b1; acc2_full = 1'b1;
    expect_ev(K_W, 0, cyc + 1);
    tick(1);
    acc1_full = 1'b0; acc2_full = 1'b0;
    tick(1);
    chk("wr_ptr_after_write", int'(wr_ptr), 4);

    // one accumulator alone is not a request
    acc1_full = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      chk("acc1_only_busy", int'(busy), 0);
      chk("acc1_only_store", int'(ub_store), 0);
    end
    acc1_full = 1'b0;

    // single read pulse
    rd_req = 1'b1;
    expect_ev(K_R, 30, cyc + 1);
    expect_ev(K_V, 30, cyc + 2);
    tick(1);
    rd_req = 1'b0;
    tick(2);
    chk("rd_ptr_after_read", int'(rd_ptr), 34);

    // sixteen back-to-back writes wrap the pointer
    ptr_ld = 1'b1; ptr_sel = 1'b0; ptr_val = 13'd0;
    tick(1);
    ptr_ld = 1'b0;
    acc1_full = 1'b1; acc2_full = 1'b1;
    for (int i = 0; i < 16; i++) expect_ev(K_W, 4 * i, cyc + 1 + 2 * i);
    tick(32);
    acc1_full = 1'b0; acc2_full = 1'b0;
    chk("wrap_wr_ptr", int'(wr_ptr), 0);
    chk("wrap_flag_set", int'(wr_wrap), 1);

    // load reduces modulo depth and clears wrap
    ptr_ld = 1'b1; ptr_sel = 1'b0; ptr_val = 13'd72;
    tick(1);
    ptr_ld = 1'b0;
    chk("load_wr_ptr", int'(wr_ptr), 8);
    chk("load_wrap_clr", int'(wr_wrap), 0);

    // load at the same edge as a write increment wins
    acc1_full = 1'b1; acc2_full = 1'b1;
    expect_ev(K_W, 8, cyc + 1);
    tick(1);
    acc1_full = 1'b0; acc2_full = 1'b0;
    ptr_ld = 1'b1; ptr_sel = 1'b0; ptr_val = 13'd20;
    tick(1);
    ptr_ld = 1'b0;
    chk("load_beats_inc", int'(wr_ptr), 20);

    // reset during READ aborts it
    rd_req = 1'b1;
    expect_ev(K_R, 34, cyc + 1);
    tick(1);
    rd_req = 1'b0;
    #5;
    reset = 1'b0;
    #1;
    chk("abort_load_strobe", int'(ub_load_input), 0);
    chk("abort_busy", int'(busy), 0);
    tick(1);
    reset = 1'b1;
    tick(1);
    chk("abort_rd_ptr", int'(rd_ptr), 30);
    chk("abort_wr_ptr", int'(wr_ptr), 0);

    // continuous contention
    acc1_full = 1'b1; acc2_full = 1'b1; rd_req = 1'b1;
    c = cyc;
`ifdef UB_SCHED_RR_EN
    expect_ev(K_W, 0,  c + 1);
    expect_ev(K_R, 30, c + 3);
    expect_ev(K_V, 30, c + 4);
    expect_ev(K_W, 4,  c + 6);
    expect_ev(K_R, 34, c + 8);
    expect_ev(K_V, 34, c + 9);
`else
    for (int i = 0; i < 5; i++) expect_ev(K_W, 4 * i, c + 1 + 2 * i);
`endif
    tick(10);
    acc1_full = 1'b0; acc2_full = 1'b0; rd_req = 1'b0;
    tick(3);
`ifdef UB_SCHED_RR_EN
    chk("contend_wr_ptr", int'(wr_ptr), 8);
    chk("contend_rd_ptr", int'(rd_ptr), 38);
`else
    chk("contend_wr_ptr", int'(wr_ptr), 20);
    chk("contend_rd_ptr", int'(rd_ptr), 30);
`endif
    chk("pending_events", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
